// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution filter and its pooling stage.
package conv_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } pool_state_t;

  // 28x28 input through a 3x3 valid convolution
  localparam int unsigned CONV_IMG_W = 26;
  localparam int unsigned CONV_IMG_H = 26;

  // Unsigned maximum of two pixels
  function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for 2x2 max pooling: one write port, one combinational read port.
module pool_line_buf
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH = 13,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  pixel_t mem_q [DEPTH];

  // Storage carries no reset: every entry is written in an even row before it is read
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Combinational read of the horizontal pair max stored for this column pair
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/conv_maxpool.sv
// Optional ReLU followed by 2x2 stride-2 max pooling of a raster-order pixel stream.
module conv_maxpool
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W   = CONV_IMG_W,
  parameter int unsigned IMG_H   = CONV_IMG_H,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] pixel_i,
  input  logic       pixel_valid_i,
  input  logic       frame_done_i,
  output logic [7:0] pool_o,
  output logic       pool_valid_o,
  output logic       pool_done_o,
  output logic       frame_err_o
);

  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam int unsigned DEPTH = IMG_W / 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam bit ODD_W = (IMG_W % 2) == 1;
  localparam bit ODD_H = (IMG_H % 2) == 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  pool_state_t   state_q, state_d;
  pixel_t        hmax_q, hmax_d;
  pixel_t        pool_q, pool_d;
  logic          pool_valid_q, pool_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  pixel_t        x;
  pixel_t        pair;
  pixel_t        lb_rdata;
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  logic          col_last, row_last, at_origin, last_acc, abort, accept;
  logic          usable;

  // ReLU clamp, position decode and frame-abort qualification
  always_comb begin
    x         = (RELU_EN && pixel_i[7]) ? '0 : pixel_i;
    pair      = pix_max(hmax_q, x);
    col_last  = (col_q == COL_LAST);
    row_last  = (row_q == ROW_LAST);
    at_origin = (col_q == '0) && (row_q == '0);
    last_acc  = pixel_valid_i && col_last && row_last;
    // a done strobe is only an error when it cuts a frame short
    abort     = frame_done_i && !at_origin && !last_acc;
    accept    = pixel_valid_i && !abort;
    // trailing odd column/row are counted but never pooled
    usable    = col_q[0] && !(ODD_W && col_last) && !(ODD_H && row_last);
    lb_addr   = AW'(col_q >> 1);
  end

  pool_line_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk_i   (clk_i),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (pair),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  // Next-state: counters, row-parity FSM, pooling datapath and strobes
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    state_d      = state_q;
    hmax_d       = hmax_q;
    pool_d       = pool_q;
    pool_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    lb_we        = 1'b0;

    if (abort) begin
      col_d   = '0;
      row_d   = '0;
      state_d = S_EVEN;
      err_d   = 1'b1;
    end else if (accept) begin
      if (!col_q[0]) hmax_d = x;

      if (usable) begin
        unique case (state_q)
          S_EVEN: lb_we = 1'b1;
          S_ODD: begin
            pool_d       = pix_max(pair, lb_rdata);
            pool_valid_d = 1'b1;
          end
          default: ;
        endcase
      end

      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d   = '0;
          state_d = S_EVEN;
          done_d  = 1'b1;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = (state_q == S_EVEN) ? S_ODD : S_EVEN;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= S_EVEN;
      hmax_q       <= '0;
      pool_q       <= '0;
      pool_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      hmax_q       <= hmax_d;
      pool_q       <= pool_d;
      pool_valid_q <= pool_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign pool_o       = pool_q;
  assign pool_valid_o = pool_valid_q;
  assign pool_done_o  = done_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench for conv_maxpool: three instances (4x4 unsigned, 5x5 unsigned, 4x4 ReLU).
module tb_conv_maxpool;

  typedef struct {
    int unsigned inst;
    int unsigned val;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix  [3];
  logic       vld  [3];
  logic       fdn  [3];
  logic [7:0] po   [3];
  logic       pv   [3];
  logic       pd   [3];
  logic       pe   [3];

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned frm [64];
  exp_t pq[$];
  exp_t dq[$];
  exp_t eq[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_maxpool #(.IMG_W(4), .IMG_H(4), .RELU_EN(1'b0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .pixel_i(pix[0]), .pixel_valid_i(vld[0]),
    .frame_done_i(fdn[0]), .pool_o(po[0]), .pool_valid_o(pv[0]),
    .pool_done_o(pd[0]), .frame_err_o(pe[0]));

  conv_maxpool #(.IMG_W(5), .IMG_H(5), .RELU_EN(1'b0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .pixel_i(pix[1]), .pixel_valid_i(vld[1]),
    .frame_done_i(fdn[1]), .pool_o(po[1]), .pool_valid_o(pv[1]),
    .pool_done_o(pd[1]), .frame_err_o(pe[1]));

  conv_maxpool #(.IMG_W(4), .IMG_H(4), .RELU_EN(1'b1)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .pixel_i(pix[2]), .pixel_valid_i(vld[2]),
    .frame_done_i(fdn[2]), .pool_o(po[2]), .pool_valid_o(pv[2]),
    .pool_done_o(pd[2]), .frame_err_o(pe[2]));

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic int unsigned rl(input int unsigned v, input bit en);
    return (en && v[7]) ? 0 : (v & 8'hFF);
  endfunction

  function automatic int unsigned mx(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      for (int unsigned i = 0; i < 3; i++) begin
        vld[i] = 1'b0;
        fdn[i] = 1'b0;
      end
      step();
    end
  endtask

  // Drive frm[] into one instance; abort_at/stop_at < 0 mean "none"
  task automatic send_frame(input int unsigned inst, input int unsigned w, input int unsigned h,
                            input bit relu, input bit gaps, input int abort_at,
                            input int stop_at, input bit done_last);
    int unsigned r, c, v;
    exp_t e;
    for (int unsigned idx = 0; idx < w * h; idx++) begin
      if (stop_at >= 0 && idx == unsigned'(stop_at)) break;
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          vld[inst] = 1'b0;
          fdn[inst] = 1'b0;
          step();
        end
      end
      pix[inst] = frm[idx][7:0];
      vld[inst] = 1'b1;
      if (abort_at >= 0 && idx == unsigned'(abort_at)) begin
        fdn[inst] = 1'b1;
        e.inst = inst; e.val = 1; e.cyc = cyc + 1;
        eq.push_back(e);
        step();
        break;
      end
      fdn[inst] = done_last && (idx == w * h - 1);
      r = idx / w;
      c = idx % w;
      if ((r % 2 == 1) && (c % 2 == 1) && (c < 2 * (w / 2)) && (r < 2 * (h / 2))) begin
        v = mx(mx(rl(frm[(r-1)*w + c-1], relu), rl(frm[(r-1)*w + c], relu)),
               mx(rl(frm[r*w + c-1], relu), rl(frm[r*w + c], relu)));
        e.inst = inst; e.val = v; e.cyc = cyc + 1;
        pq.push_back(e);
      end
      if (idx == w * h - 1) begin
        e.inst = inst; e.val = 1; e.cyc = cyc + 1;
        dq.push_back(e);
      end
      step();
    end
    vld[inst] = 1'b0;
    fdn[inst] = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int unsigned i = 0; i < 64; i++) frm[i] = i;
  endtask

  task automatic fill_rand();
    for (int unsigned i = 0; i < 64; i++) frm[i] = $urandom_range(255, 0);
  endtask

  // Output monitor: pooled values against the scoreboard, done/err pulses against expected cycles
  always @(negedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (pv[i]) begin
        if (pq.size() == 0) check_val("pool_unexpected", 1, 0);
        else begin
          mon_e = pq.pop_front();
          check_val("pool_inst", i, mon_e.inst);
          check_val("pool_val", po[i], mon_e.val);
          check_val("pool_cycle", cyc, mon_e.cyc);
        end
      end else if (pq.size() != 0 && pq[0].inst == i && pq[0].cyc <= cyc) begin
        check_val("pool_missing", 0, 1);
        void'(pq.pop_front());
      end

      if (pd[i] || (dq.size() != 0 && dq[0].inst == i && dq[0].cyc == cyc)) begin
        check_val("done_pulse", pd[i], (dq.size() != 0 && dq[0].inst == i && dq[0].cyc == cyc));
        if (dq.size() != 0 && dq[0].inst == i && dq[0].cyc == cyc) void'(dq.pop_front());
      end

      if (pe[i] || (eq.size() != 0 && eq[0].inst == i && eq[0].cyc == cyc)) begin
        check_val("err_pulse", pe[i], (eq.size() != 0 && eq[0].inst == i && eq[0].cyc == cyc));
        if (eq.size() != 0 && eq[0].inst == i && eq[0].cyc == cyc) void'(eq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < 3; i++) begin
      pix[i] = '0;
      vld[i] = 1'b0;
      fdn[i] = 1'b0;
    end
    #2;
    for (int unsigned i = 0; i < 3; i++) begin
      check_val("rst_pool", po[i], 0);
      check_val("rst_valid", pv[i], 0);
      check_val("rst_done", pd[i], 0);
      check_val("rst_err", pe[i], 0);
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // 4x4 ramp, back-to-back: 5,7,13,15 with done alongside 15
    fill_ramp();
    send_frame(0, 4, 4, 1'b0, 1'b0, -1, -1, 1'b0);
    idle(3);

    // ReLU blocks {80,F0,FF,90} -> 0 and {FF,03,7F,80} -> 7F
    fill_rand();
    frm[0] = 8'h80; frm[1] = 8'hF0; frm[4] = 8'hFF; frm[5] = 8'h90;
    frm[2] = 8'hFF; frm[3] = 8'h03; frm[6] = 8'h7F; frm[7] = 8'h80;
    send_frame(2, 4, 4, 1'b1, 1'b0, -1, -1, 1'b0);
    idle(3);
    fill_rand();
    send_frame(2, 4, 4, 1'b1, 1'b1, -1, -1, 1'b0);
    idle(3);

    // 5x5 ramp: 6,8,16,18, trailing column/row ignored
    fill_ramp();
    send_frame(1, 5, 5, 1'b0, 1'b0, -1, -1, 1'b0);
    idle(3);
    fill_rand();
    send_frame(1, 5, 5, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(3);

    // ramp again with random valid gaps
    fill_ramp();
    send_frame(0, 4, 4, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(3);

    // frame_done at origin is ignored
    fdn[0] = 1'b1;
    step();
    fdn[0] = 1'b0;
    idle(2);

    // abort after 6 pixels (done arrives together with the 7th pixel), then a clean frame
    send_frame(0, 4, 4, 1'b0, 1'b0, 6, -1, 1'b0);
    idle(3);
    send_frame(0, 4, 4, 1'b0, 1'b0, -1, -1, 1'b0);
    idle(3);

    // frame_done coinciding with the final pixel is a normal completion
    fill_rand();
    send_frame(0, 4, 4, 1'b0, 1'b1, -1, -1, 1'b1);
    idle(3);

    // reset after 10 pixels: outputs clear at once, nothing pending afterwards
    fill_ramp();
    send_frame(0, 4, 4, 1'b0, 1'b0, -1, 10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_pool", po[0], 0);
    check_val("midrst_valid", pv[0], 0);
    check_val("midrst_done", pd[0], 0);
    check_val("midrst_err", pe[0], 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_frame(0, 4, 4, 1'b0, 1'b0, -1, -1, 1'b0);
    idle(3);
    fill_rand();
    send_frame(0, 4, 4, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(4);

    check_val("drain_pool", pq.size(), 0);
    check_val("drain_done", dq.size(), 0);
    check_val("drain_err", eq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
